// File: rtl/data_mem_ctrl_if.sv
// ----------------------------------------------------------------------------
// data_mem_ctrl_if
//   Load/store bus between the processor's memory port and the data-memory
//   stage (data_mem_ctrl).
//
//   Signals
//     mem_read_ctrlsig   master->slave  load request, level, held until ready
//     mem_write_ctrlsig  master->slave  store request, level, held until ready
//     data_addr   [31:0] master->slave  byte address
//     data_in     [31:0] master->slave  store data
//     data_out    [31:0] slave->master  load data, held until next load
//     mem_ready          slave->master  one-cycle pulse: access complete
//     mem_busy           slave->master  high while an access is in flight
//     addr_err           slave->master  pulse with mem_ready: access rejected
//
//   Modports
//     master : processor side (drives requests)
//     slave  : memory side (drives results)
// ----------------------------------------------------------------------------
interface data_mem_ctrl_if;
    logic        mem_read_ctrlsig;
    logic        mem_write_ctrlsig;
    logic [31:0] data_addr;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        mem_ready;
    logic        mem_busy;
    logic        addr_err;

    modport master (
        output mem_read_ctrlsig,
        output mem_write_ctrlsig,
        output data_addr,
        output data_in,
        input  data_out,
        input  mem_ready,
        input  mem_busy,
        input  addr_err
    );

    modport slave (
        input  mem_read_ctrlsig,
        input  mem_write_ctrlsig,
        input  data_addr,
        input  data_in,
        output data_out,
        output mem_ready,
        output mem_busy,
        output addr_err
    );
endinterface

// File: rtl/data_mem_ctrl.sv
// ----------------------------------------------------------------------------
// data_mem_ctrl
//   Data-memory stage behind the processor's load/store port. A request seen
//   in IDLE is latched, the controller waits WAIT_CYCLES wait states, then
//   performs one 32-bit word access on an internal RAM and pulses mem_ready
//   for one cycle. Out-of-range accesses are rejected with addr_err.
//
//   Parameters
//     DEPTH_LOG2   log2 of RAM depth in 32-bit words
//     WAIT_CYCLES  wait states per access (0..15)
//     BASE_ADDR    byte address of RAM word 0
//
//   Ports
//     clk   in   clock, all state updates on posedge
//     rst   in   synchronous reset, active-high (RAM contents not reset)
//     bus   slave modport of data_mem_ctrl_if (requests in, results out)
//
//   Configuration
//     DMEM_ALIGN_CHECK_EN  when defined, addresses with addr[1:0] != 0 are
//                          rejected with addr_err; otherwise the low two
//                          address bits are ignored and the enclosing word
//                          is accessed.
// ----------------------------------------------------------------------------
module data_mem_ctrl #(
    parameter int          DEPTH_LOG2  = 10,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic             clk,
    input  logic             rst,
    data_mem_ctrl_if.slave   bus
);

    localparam int         DEPTH     = 1 << DEPTH_LOG2;
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);
    localparam bit         NO_WAIT   = (WAIT_CYCLES == 0);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } state_t;

    state_t                  state_q;
    logic [3:0]              cnt_q;
    logic                    opWrite_q;
    logic [31:0]             addr_q;
    logic [31:0]             wdata_q;
    logic [31:0]             dataOut_q;
    logic                    ready_q;
    logic                    busy_q;
    logic                    addrErr_q;
    logic [31:0]             mem_q [DEPTH];

    logic                    reqSeen;
    logic                    commit;
    logic                    accWrite;
    logic [31:0]             accAddr;
    logic [31:0]             accData;
    logic [31:0]             offset;
    logic                    inRange;
    logic [DEPTH_LOG2-1:0]   accIdx;
    logic                    alignErr;
    logic                    accErr;

    // A request is only taken in IDLE; a simultaneous read+write is a write.
    assign reqSeen = (state_q == IDLE) &&
                     (bus.mem_read_ctrlsig || bus.mem_write_ctrlsig);

    // The access commits on the edge entering DONE. With zero wait states
    // that is the same edge that samples the request, so the live bus
    // values are used instead of the (not yet loaded) latches.
    assign commit = (reqSeen && NO_WAIT) ||
                    ((state_q == WAIT) && (cnt_q == 4'd1));

    assign accWrite = (state_q == IDLE) ? bus.mem_write_ctrlsig : opWrite_q;
    assign accAddr  = (state_q == IDLE) ? bus.data_addr         : addr_q;
    assign accData  = (state_q == IDLE) ? bus.data_in           : wdata_q;

    // Addresses below BASE_ADDR wrap to a huge offset and land out of range,
    // so a single upper-bits-zero test covers both ends.
    assign offset  = accAddr - BASE_ADDR;
    assign inRange = (offset[31:DEPTH_LOG2+2] == '0);
    assign accIdx  = offset[DEPTH_LOG2+1:2];

`ifdef DMEM_ALIGN_CHECK_EN
    assign alignErr = (accAddr[1:0] != 2'b00);
`else
    logic unusedOffsetBits;
    assign unusedOffsetBits = ^offset[1:0];
    assign alignErr = 1'b0;
`endif

    assign accErr = !inRange || alignErr;

    // Control FSM with registered outputs. ready/busy/err are set on the
    // edge that enters their state so they line up with the state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            opWrite_q <= 1'b0;
            addr_q    <= 32'd0;
            wdata_q   <= 32'd0;
            dataOut_q <= 32'd0;
            ready_q   <= 1'b0;
            busy_q    <= 1'b0;
            addrErr_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    ready_q   <= 1'b0;
                    addrErr_q <= 1'b0;
                    if (reqSeen) begin
                        opWrite_q <= bus.mem_write_ctrlsig;
                        addr_q    <= bus.data_addr;
                        wdata_q   <= bus.data_in;
                        busy_q    <= 1'b1;
                        if (NO_WAIT) begin
                            state_q   <= DONE;
                            ready_q   <= 1'b1;
                            addrErr_q <= accErr;
                        end else begin
                            state_q <= WAIT;
                            cnt_q   <= WAIT_INIT;
                        end
                    end
                end
                WAIT: begin
                    if (cnt_q == 4'd1) begin
                        state_q   <= DONE;
                        ready_q   <= 1'b1;
                        addrErr_q <= accErr;
                    end
                    cnt_q <= cnt_q - 4'd1;
                end
                DONE: begin
                    state_q   <= IDLE;
                    ready_q   <= 1'b0;
                    addrErr_q <= 1'b0;
                    busy_q    <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase

            // Load data is updated only by a completing read; rejected
            // reads return zero.
            if (commit && !accWrite) begin
                dataOut_q <= accErr ? 32'd0 : mem_q[accIdx];
            end
        end
    end

    // RAM write port. Gated by rst so an access aborted by reset on its
    // commit edge never reaches the array. Contents are not reset.
    always_ff @(posedge clk) begin
        if (!rst && commit && accWrite && !accErr) begin
            mem_q[accIdx] <= accData;
        end
    end

    assign bus.data_out  = dataOut_q;
    assign bus.mem_ready = ready_q;
    assign bus.mem_busy  = busy_q;
    assign bus.addr_err  = addrErr_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// ----------------------------------------------------------------------------
// tb_data_mem_ctrl
//   Self-checking bench for data_mem_ctrl (DEPTH_LOG2=10, WAIT_CYCLES=2,
//   BASE_ADDR=0). Expected results are computed from a word-level memory
//   model and queued when a request is driven, then popped and compared when
//   the DUT pulses mem_ready. Honours DMEM_ALIGN_CHECK_EN for the misaligned
//   read expectation.
// ----------------------------------------------------------------------------
module tb_data_mem_ctrl;

    localparam int          DEPTH_LOG2  = 10;
    localparam int          WAIT_CYCLES = 2;
    localparam logic [31:0] BASE        = 32'h0000_0000;
    localparam int          DEPTH       = 1 << DEPTH_LOG2;

    typedef struct {
        string       tag;
        logic [31:0] data;
        logic        err;
    } expEntry_t;

    logic clk;
    logic rst;
    int   vecCount;
    int   missCount;

    expEntry_t   expQ [$];
    logic [31:0] model [int];
    logic [31:0] lastOut;

    data_mem_ctrl_if bus ();

    data_mem_ctrl #(
        .DEPTH_LOG2  (DEPTH_LOG2),
        .WAIT_CYCLES (WAIT_CYCLES),
        .BASE_ADDR   (BASE)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single point of comparison: counts every vector and reports misses.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vecCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Drive one request, queue its expected result, wait (bounded) for
    // mem_ready, then pop and compare latency, data_out and addr_err.
    task automatic applyStimulus(input string tag, input bit rd, input bit wr,
                                 input logic [31:0] addr, input logic [31:0] data);
        expEntry_t   e;
        expEntry_t   got;
        logic [31:0] off;
        int          idx;
        int          n;
        bit          seen;

        off   = addr - BASE;
        idx   = int'(off >> 2);
        e.tag = tag;
        e.err = ((off >> 2) >= DEPTH);
`ifdef DMEM_ALIGN_CHECK_EN
        if (addr[1:0] != 2'b00) e.err = 1'b1;
`endif
        if (wr) begin
            e.data = lastOut;
            if (!e.err) model[idx] = data;
        end else begin
            e.data  = e.err ? 32'd0 : model[idx];
            lastOut = e.data;
        end
        expQ.push_back(e);

        @(negedge clk);
        bus.mem_read_ctrlsig  = rd;
        bus.mem_write_ctrlsig = wr;
        bus.data_addr         = addr;
        bus.data_in           = data;

        seen = 1'b0;
        n    = 0;
        while (!seen && n < 32) begin
            @(posedge clk);
            #1;
            n++;
            if (n == 1) checkOutput({tag, " busy"}, 32'(bus.mem_busy), 32'd1);
            if (bus.mem_ready) seen = 1'b1;
        end

        got = expQ.pop_front();
        if (!seen) begin
            checkOutput({got.tag, " timeout"}, 32'd0, 32'd1);
        end else begin
            checkOutput({got.tag, " latency"}, 32'(n), 32'(WAIT_CYCLES + 1));
            checkOutput({got.tag, " data_out"}, bus.data_out, got.data);
            checkOutput({got.tag, " addr_err"}, 32'(bus.addr_err), 32'(got.err));
        end

        @(negedge clk);
        bus.mem_read_ctrlsig  = 1'b0;
        bus.mem_write_ctrlsig = 1'b0;
        @(posedge clk);
        #1;
        checkOutput({tag, " ready drop"}, 32'(bus.mem_ready), 32'd0);
        checkOutput({tag, " busy drop"}, 32'(bus.mem_busy), 32'd0);
    endtask

    // Main sequence.
    initial begin
        logic [31:0] rAddr [8];
        logic [31:0] rData [8];
        bit          sawReady;

        vecCount  = 0;
        missCount = 0;
        lastOut   = 32'd0;
        rst       = 1'b1;
        bus.mem_read_ctrlsig  = 1'b0;
        bus.mem_write_ctrlsig = 1'b0;
        bus.data_addr         = 32'd0;
        bus.data_in           = 32'd0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            checkOutput("idle outputs",
                        {bus.data_out[31:3],
                         bus.data_out[2:0] | {bus.mem_ready, bus.mem_busy, bus.addr_err}},
                        32'd0);
        end

        applyStimulus("wr 0x10", 1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF);
        applyStimulus("rd 0x10", 1'b1, 1'b0, 32'h10, 32'h0);

        applyStimulus("wr 0xFFC", 1'b0, 1'b1, 32'hFFC, 32'hCAFE_F00D);
        applyStimulus("rd 0x1000", 1'b1, 1'b0, 32'h1000, 32'h0);
        applyStimulus("rd 0xFFC", 1'b1, 1'b0, 32'hFFC, 32'h0);
        applyStimulus("wr 0x2000", 1'b0, 1'b1, 32'h2000, 32'h0BAD_0BAD);
        applyStimulus("rd 0x0", 1'b1, 1'b0, 32'h0, 32'h0);

        applyStimulus("rdwr 0x20", 1'b1, 1'b1, 32'h20, 32'h5A5A_5A5A);
        applyStimulus("rd 0x20", 1'b1, 1'b0, 32'h20, 32'h0);

        applyStimulus("wr 0x24", 1'b0, 1'b1, 32'h24, 32'h1111_2222);
        @(negedge clk);
        bus.mem_write_ctrlsig = 1'b1;
        bus.data_addr         = 32'h24;
        bus.data_in           = 32'h1234_5678;
        @(posedge clk);
        @(negedge clk);
        rst                   = 1'b1;
        bus.mem_write_ctrlsig = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("abort busy", 32'(bus.mem_busy), 32'd0);
        checkOutput("abort data_out", bus.data_out, 32'd0);
        lastOut = 32'd0;
        @(negedge clk);
        rst = 1'b0;
        sawReady = 1'b0;
        repeat (5) begin
            @(posedge clk);
            #1;
            if (bus.mem_ready) sawReady = 1'b1;
        end
        checkOutput("abort no ready", 32'(sawReady), 32'd0);
        applyStimulus("rd 0x24 after abort", 1'b1, 1'b0, 32'h24, 32'h0);

        applyStimulus("rd 0x22", 1'b1, 1'b0, 32'h22, 32'h0);

        for (int i = 0; i < 8; i++) begin
            rAddr[i] = {20'd0, 10'($urandom_range(0, DEPTH - 1)), 2'b00};
            rData[i] = $urandom;
            applyStimulus("rand wr", 1'b0, 1'b1, rAddr[i], rData[i]);
        end
        for (int i = 0; i < 8; i++) begin
            applyStimulus("rand rd", 1'b1, 1'b0, rAddr[i], 32'h0);
        end

        checkOutput("queue empty", 32'(expQ.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
